// File: rtl/oam_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_arbiter
// Description : Sprite-OAM DMA engine sharing the core's memory bus. A core
//               write to DMA_REG_ADDR latches a source page and halts the core.
//               The engine then copies 256 bytes, {page,00}..{page,FF}, to the
//               fixed destination DMA_DST_ADDR. Each byte is one read cycle
//               followed by one write cycle.
//
// Ports       : clk       - sole clock, rising edge
//               rst_n     - asynchronous active-low reset
//               cpu_addr  - core address bus (16)
//               cpu_dout  - core write data (8)
//               cpu_rw    - core read(1)/write(0)
//               cpu_ready - core ready; low stalls core reads
//               mem_addr  - memory request address (16)
//               mem_dout  - memory write data (8)
//               mem_rw    - memory read(1)/write(0)
//               mem_din   - memory read data, one cycle after the address
//               dma_busy  - high whenever a DMA is pending or running
//               dma_done  - one-cycle pulse on the final write
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] DMA_DST_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    output logic        cpu_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_rw,
    input  logic [7:0]  mem_din,
    output logic        dma_busy,
    output logic        dma_done
);

    localparam logic [7:0] c_IDX_LAST = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_idx;
    logic [7:0] w_idx_next;
    logic [7:0] r_page;
    logic [7:0] w_page_next;
    logic       r_parity;

    // State register. The parity flop free-runs so the read/write pairs can
    // be kept on a fixed cycle phase; an odd phase costs one ALIGN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= 8'h00;
            r_page   <= 8'h00;
            r_parity <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_idx    <= w_idx_next;
            r_page   <= w_page_next;
            r_parity <= ~r_parity;
        end
    end

    // Next-state and bus steering. The core owns the bus in IDLE and HALT
    // (core writes are not stalled by ready, so they must still land).
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_page_next  = r_page;
        mem_addr     = cpu_addr;
        mem_dout     = cpu_dout;
        mem_rw       = cpu_rw;
        dma_done     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!cpu_rw && (cpu_addr == DMA_REG_ADDR)) begin
                    w_page_next  = cpu_dout;
                    w_idx_next   = 8'h00;
                    w_state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (cpu_rw) begin
                    w_state_next = r_parity ? ST_ALIGN : ST_READ;
                end
            end
            ST_ALIGN: begin
                mem_rw       = 1'b1;
                w_state_next = ST_READ;
            end
            ST_READ: begin
                mem_addr     = {r_page, r_idx};
                mem_rw       = 1'b1;
                w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                // mem_din carries the byte addressed during the preceding READ
                mem_addr   = DMA_DST_ADDR;
                mem_rw     = 1'b0;
                mem_dout   = mem_din;
                w_idx_next = r_idx + 8'd1;
                if (r_idx == c_IDX_LAST) begin
                    dma_done     = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_READ;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign cpu_ready = (r_state == ST_IDLE);
    assign dma_busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_oam_dma_arbiter
// Description : Self-checking bench for oam_dma_arbiter. Each trigger pushes
//               the expected per-cycle bus activity of the busy window into a
//               queue; a negedge monitor pops and compares while dma_busy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw;
    logic        cpu_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_rw;
    logic [7:0]  mem_din;
    logic        dma_busy;
    logic        dma_done;

    oam_dma_arbiter #(
        .DMA_REG_ADDR(16'h4014),
        .DMA_DST_ADDR(16'h2004)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_rw   (cpu_rw),
        .cpu_ready(cpu_ready),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .mem_rw   (mem_rw),
        .mem_din  (mem_din),
        .dma_busy (dma_busy),
        .dma_done (dma_done)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data appears one cycle after the address.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        mem_din <= mem[mem_addr];
        if (mem_rw === 1'b0) mem[mem_addr] <= mem_dout;
    end

    // Edges since reset release; its LSB is the phase the DUT aligns to.
    int unsigned cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
        bit          chk;
    } bus_t;

    bus_t exp_q[$];
    bus_t e_mon;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   busy_cyc = 0;
    int   stray_wr = 0;

    always @(negedge clk) begin
        if (dma_busy === 1'b0 && mem_rw === 1'b0 && mem_addr === 16'h2004) stray_wr++;
        if (rst_n === 1'b1) begin
            if (dma_busy === 1'b1) begin
                busy_cyc++;
                checks++;
                if (cpu_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_busy: cpu_ready=%b, required 0", cpu_ready);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_extra: got addr=%h rw=%b, required no busy cycle", mem_addr, mem_rw);
                end else begin
                    e_mon = exp_q.pop_front();
                    if (mem_addr !== e_mon.addr || mem_rw !== e_mon.rw ||
                        (e_mon.chk && mem_dout !== e_mon.data)) begin
                        errors++;
                        $display("FAIL bus_cmp: got addr=%h rw=%b dout=%h, required addr=%h rw=%b dout=%h",
                                 mem_addr, mem_rw, mem_dout, e_mon.addr, e_mon.rw, e_mon.data);
                    end
                end
                if (dma_done === 1'b1) begin
                    done_cnt++;
                    checks++;
                    if (exp_q.size() != 0 || mem_rw !== 1'b0) begin
                        errors++;
                        $display("FAIL done_timing: pending=%0d rw=%b, required 0 pending on a write",
                                 exp_q.size(), mem_rw);
                    end
                end
            end else begin
                checks++;
                if (dma_done !== 1'b0) begin
                    errors++;
                    $display("FAIL done_idle: dma_done=%b, required 0", dma_done);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read_idle();
        cpu_addr = 16'h8000;
        cpu_dout = 8'h00;
        cpu_rw   = 1'b1;
    endtask

    // Issue a trigger (plus optional HALT writes and the releasing read) and
    // push the expected busy-window bus activity. want_align selects the phase
    // unless immediate is set, in which case the trigger goes out right away.
    task automatic start_dma(input logic [7:0] page, input int hold, input bit want_align,
                             input bit immediate, output bit al);
        logic [15:0] a;
        if (!immediate) begin
            step();
            if ((((cyc + 1 + hold) & 1) == 1) != want_align) step();
        end
        cpu_addr = 16'h4014;
        cpu_dout = page;
        cpu_rw   = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_addr !== 16'h4014 || mem_rw !== 1'b0 || mem_dout !== page ||
            cpu_ready !== 1'b1 || dma_busy !== 1'b0) begin
            errors++;
            $display("FAIL trigger_pass: addr=%h rw=%b dout=%h ready=%b busy=%b, required 4014 0 %h 1 0",
                     mem_addr, mem_rw, mem_dout, cpu_ready, dma_busy, page);
        end
        step();
        for (int h = 0; h < hold; h++) begin
            cpu_addr = 16'h01FD - 16'(h);
            cpu_dout = 8'h40 + 8'(h);
            cpu_rw   = 1'b0;
            exp_q.push_back('{cpu_addr, 1'b0, cpu_dout, 1'b1});
            step();
        end
        cpu_read_idle();
        exp_q.push_back('{16'h8000, 1'b1, 8'h00, 1'b0});
        al = cyc[0];
        if (al) exp_q.push_back('{16'h8000, 1'b1, 8'h00, 1'b0});
        for (int i = 0; i < 256; i++) begin
            a = {page, 8'(i)};
            exp_q.push_back('{a, 1'b1, 8'h00, 1'b0});
            exp_q.push_back('{16'h2004, 1'b0, mem[a], 1'b1});
        end
    endtask

    task automatic wait_done(input string nm, input int target, input int exp_busy);
        for (int n = 0; n < 1200 && done_cnt < target; n++) step();
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout: done pulses=%0d, required %0d", nm, done_cnt, target);
            exp_q.delete();
        end else if (busy_cyc != exp_busy) begin
            errors++;
            $display("FAIL %s_busy_len: busy cycles=%0d, required %0d", nm, busy_cyc, exp_busy);
        end
    endtask

    task automatic check_idle(input string nm);
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (dma_busy !== 1'b0 || cpu_ready !== 1'b1 || exp_q.size() != 0) begin
                errors++;
                $display("FAIL %s_idle: busy=%b ready=%b pending=%0d, required 0 1 0",
                         nm, dma_busy, cpu_ready, exp_q.size());
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        cpu_addr = 16'h1234;
        cpu_dout = 8'h56;
        cpu_rw   = 1'b0;
        step();
        checks++;
        if (cpu_ready !== 1'b1 || dma_busy !== 1'b0 || dma_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b busy=%b done=%b, required 1 0 0", cpu_ready, dma_busy, dma_done);
        end
        checks++;
        if (mem_addr !== 16'h1234 || mem_dout !== 8'h56 || mem_rw !== 1'b0) begin
            errors++;
            $display("FAIL reset_pass: addr=%h dout=%h rw=%b, required 1234 56 0", mem_addr, mem_dout, mem_rw);
        end
        step();
        cpu_read_idle();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_even();
        bit al;
        busy_cyc = 0;
        start_dma(8'h02, 0, 1'b0, 1'b0, al);
        wait_done("even", 1, 513);
        check_idle("even");
    endtask

    task automatic test_odd();
        bit al;
        busy_cyc = 0;
        start_dma(8'h02, 0, 1'b1, 1'b0, al);
        wait_done("odd", 2, 514);
        check_idle("odd");
    endtask

    task automatic test_write_hold();
        bit al;
        busy_cyc = 0;
        start_dma(8'h02, 2, 1'b0, 1'b0, al);
        wait_done("hold", 3, 515);
        check_idle("hold");
    endtask

    task automatic test_back_to_back();
        bit al;
        for (int i = 0; i < 256; i++) mem[16'h0300 + 16'(i)] = 8'(i) ^ 8'hA5;
        busy_cyc = 0;
        start_dma(8'h03, 0, 1'b0, 1'b0, al);
        wait_done("data", 4, 513);
        // Re-trigger in the very first IDLE cycle; source restarts at {page,00}.
        busy_cyc = 0;
        start_dma(8'h03, 0, 1'b0, 1'b1, al);
        wait_done("b2b", 5, 513 + int'(al));
        check_idle("b2b");
    endtask

    task automatic test_retrigger();
        bit al;
        busy_cyc = 0;
        start_dma(8'h02, 0, 1'b0, 1'b0, al);
        for (int n = 0; n < 600 && exp_q.size() > 312; n++) step();
        cpu_addr = 16'h4014;
        cpu_dout = 8'h07;
        cpu_rw   = 1'b0;
        step();
        cpu_read_idle();
        wait_done("retrig", 6, 513);
        check_idle("retrig");
    endtask

    task automatic test_reset_mid();
        bit al;
        busy_cyc = 0;
        start_dma(8'h02, 0, 1'b0, 1'b0, al);
        for (int n = 0; n < 600 && exp_q.size() > 412; n++) step();
        stray_wr = 0;
        rst_n    = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (cpu_ready !== 1'b1 || dma_busy !== 1'b0 || mem_addr !== 16'h8000 || mem_rw !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: ready=%b busy=%b addr=%h rw=%b, required 1 0 8000 1",
                     cpu_ready, dma_busy, mem_addr, mem_rw);
        end
        for (int n = 0; n < 3; n++) step();
        rst_n = 1'b1;
        check_idle("midreset");
        checks++;
        if (stray_wr != 0) begin
            errors++;
            $display("FAIL midreset_stray: writes to 2004=%0d, required 0", stray_wr);
        end
        // Normal operation after reset, with the phase counted from zero.
        busy_cyc = 0;
        start_dma(8'h02, 0, 1'b1, 1'b0, al);
        wait_done("postreset", 7, 514);
        check_idle("postreset");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i * 7 + 3);
        test_reset();
        test_even();
        test_odd();
        test_write_hold();
        test_back_to_back();
        test_retrigger();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, meaning the CPU write address that triggers a DMA.
REQ-002 SHALL have parameter DMA_DST_ADDR, default 16'h2004, meaning the fixed write-destination address for every transferred byte.
REQ-003 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: cpu_addr  in  16  core address bus; cpu_dout  in  8  core write data; cpu_rw  in  1  core read(1)/write(0).
REQ-006 SHALL have ports: cpu_ready  out  1  core ready; low stalls core reads.
REQ-007 SHALL have ports: mem_addr  out  16; mem_dout  out  8; mem_rw  out  1; these form the synchronous-memory request bus.
REQ-008 SHALL have ports: mem_din  in  8  memory read data, valid one cycle after the address; this is also wired externally to core data_i.
REQ-009 SHALL have ports: dma_busy  out  1  high in any non-IDLE state; dma_done  out  1  one-cycle pulse on completion.

Function
REQ-010 SHALL implement states IDLE, HALT, ALIGN, READ, WRITE, plus 8-bit idx, 8-bit page, and a 1-bit parity flop that toggles every cycle after reset.
REQ-011 SHALL, in IDLE and HALT, pass the CPU bus through: mem_addr=cpu_addr, mem_dout=cpu_dout, mem_rw=cpu_rw.
REQ-012 SHALL, in IDLE at a clock edge with cpu_rw=0 and cpu_addr==DMA_REG_ADDR, latch page<=cpu_dout, set idx<=0 and go to HALT; the triggering write still reaches memory.
REQ-013 SHALL drive cpu_ready=1 only in IDLE (combinational from state), so cpu_ready is low from the cycle after the trigger.
REQ-014 SHALL stay in HALT while cpu_rw=0, because core writes ignore ready; those writes pass through to memory.
REQ-015 SHALL leave HALT at the first edge with cpu_rw=1, going to ALIGN if parity=1 and to READ if parity=0.
REQ-016 SHALL make ALIGN last exactly one cycle, bus idle (mem_addr=cpu_addr, mem_rw=1), then go to READ.
REQ-017 SHALL, in READ, drive mem_addr={page,idx}, mem_rw=1, then go to WRITE.
REQ-018 SHALL, in WRITE, drive mem_addr=DMA_DST_ADDR, mem_rw=0, mem_dout=mem_din, and increment idx mod 256.
REQ-019 SHALL, in WRITE with idx==8'hFF, go to IDLE with idx wrapped to 0 and assert dma_done for that one cycle; otherwise WRITE returns to READ.
REQ-020 SHALL ignore cpu_addr, cpu_dout and cpu_rw in ALIGN, READ and WRITE; a CPU write to DMA_REG_ADDR while busy neither restarts nor alters page.
REQ-021 SHALL transfer exactly 256 bytes, in ascending source order {page,00}..{page,FF}, per trigger.
REQ-022 SHALL take 512 cycles from first READ to return to IDLE, plus one ALIGN cycle when parity is odd.
REQ-023 SHALL accept a new trigger in the first IDLE cycle after completion.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force state=IDLE, idx=0, page=0, parity=0, dma_done=0.
REQ-025 SHALL, while rst_n=0, hold cpu_ready=1, dma_busy=0 and the CPU bus passed through per REQ-011.
REQ-026 SHALL abort any transfer in progress on reset assertion mid-DMA, with no further DMA write after rst_n falls.
REQ-027 SHALL begin operating normally on the first rising edge after rst_n deasserts, with parity counting from 0.

Verification
REQ-028 SHALL be covered by an even-parity trigger: CPU writes 8'h02 to 16'h4014, then reads -> READ at 16'h0200..16'h02FF each followed by a write of that data to 16'h2004; dma_busy high for 513 cycles; one dma_done pulse.
REQ-029 SHALL be covered by an odd-parity trigger: same stimulus issued one cycle later -> exactly one ALIGN cycle before the first read at 16'h0200.
REQ-030 SHALL be covered by a write-hold case: trigger followed by two further core writes (stack pushes) -> both reach memory in HALT, and the DMA starts only after cpu_rw=1.
REQ-031 SHALL be covered by a data-integrity case: memory 16'h0300+i = i^8'hA5 -> 256 writes to 16'h2004 with data i^8'hA5 in order; idx wraps to 0.
REQ-032 SHALL be covered by a busy retrigger: write 8'h07 to 16'h4014 at byte 100 -> ignored, and source addresses stay in page 8'h02.
REQ-033 SHALL be covered by mid-transfer reset: assert rst_n=0 at byte 50 -> immediately cpu_ready=1, dma_busy=0, with no write to 16'h2004 afterwards.
